// File: rtl/tns_cac_encoder_mc_pkg.sv
// Shared types and helpers for the multi-group TNS crosstalk-avoidance encoder:
// radix, symbol type, FSM states, and the per-group symbol encode/decode rules.
package tns_pkg;

    localparam int unsigned RADIX = 7;
    localparam int unsigned SYM_W = 3;

    typedef logic [SYM_W-1:0] tns_sym_t;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LAUNCH
    } tns_state_e;

    // 7**n, usable both in constant context and for unrolled datapath weights
    function automatic logic [31:0] pow7(input int unsigned n);
        logic [31:0] r;
        r = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 32'(RADIX);
        end
        return r;
    endfunction

    // Skip 3'b100 when the group's previous MSB was 0, skip 3'b011 when it was 1
    function automatic tns_sym_t tns_enc(input tns_sym_t s, input logic p);
        tns_sym_t lim;
        lim = p ? 3'd3 : 3'd4;
        return (s < lim) ? s : s + 3'd1;
    endfunction

    function automatic tns_sym_t tns_dec(input tns_sym_t t, input logic p);
        tns_sym_t thr;
        thr = p ? 3'd2 : 3'd3;
        return (t > thr) ? t - 3'd1 : t;
    endfunction

endpackage

// File: rtl/tns_cac_encoder_mc_if.sv
// Input word handshake and TSV output bundle of the TNS encoder.
interface tns_cac_encoder_mc_if #(
    parameter int unsigned NGRP = 4,
    parameter int unsigned DW   = 12
);
    logic [DW-1:0]     datain;
    logic              din_valid;
    logic              din_ready;
    logic [3*NGRP-1:0] tsv;
    logic              tsv_valid;
    logic              range_err;
    logic              chk_err;

    modport master (
        output datain, din_valid,
        input  din_ready, tsv, tsv_valid, range_err, chk_err
    );

    modport slave (
        input  datain, din_valid,
        output din_ready, tsv, tsv_valid, range_err, chk_err
    );
endinterface

// File: rtl/tns_cac_encoder_mc_sym_map.sv
// Combinational map of one 3-TSV group: base-7 digit plus previous MSB -> TSV symbol.
module tns_sym_map
    import tns_pkg::*;
(
    input  tns_sym_t s,
    input  logic     p,
    output tns_sym_t t_c
);
    assign t_c = tns_enc(s, p);
endmodule

// File: rtl/tns_cac_encoder_mc.sv
// Multi-group TNS encoder: sequential base-7 digit split, then all groups launched on one edge.
// Optional self-checking decoder enabled by macro TNS_SELFCHK_EN.
module tns_cac_encoder_mc
    import tns_pkg::*;
#(
    parameter int unsigned NGRP = 4,
    parameter int unsigned DW   = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    tns_cac_encoder_mc_if.slave  bus
);

    localparam int unsigned TW = 3 * NGRP;
    localparam int unsigned LW = DW + 3;
    localparam int unsigned KW = $clog2(NGRP + 1);
    localparam logic [LW-1:0] LIMIT  = LW'(pow7(NGRP));
    localparam logic [KW-1:0] K_LAST = KW'(NGRP - 1);

    tns_state_e             state_q, state_d;
    logic [DW-1:0]          rem_q, rem_d;
    logic [KW-1:0]          k_q, k_d;
    tns_sym_t [NGRP-1:0]    dig_q, dig_d;
    logic [TW-1:0]          tsv_q, tsv_d;
    logic                   tsv_valid_q, tsv_valid_d;
    logic                   range_err_q, range_err_d;
    logic                   din_ready_q, din_ready_d;
    tns_sym_t [NGRP-1:0]    sym_c;

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_map
        tns_sym_map u_map (
            .s   (dig_q[gi]),
            .p   (tsv_q[3*gi+2]),
            .t_c (sym_c[gi])
        );
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        k_d         = k_q;
        dig_d       = dig_q;
        tsv_d       = tsv_q;
        tsv_valid_d = 1'b0;
        range_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.din_valid) begin
                    if ({3'b000, bus.datain} >= LIMIT) begin
                        range_err_d = 1'b1;
                    end else begin
                        rem_d   = bus.datain;
                        k_d     = '0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                for (int unsigned g = 0; g < NGRP; g++) begin
                    if (k_q == KW'(g)) begin
                        dig_d[g] = SYM_W'(rem_q % DW'(RADIX));
                    end
                end
                rem_d = rem_q / DW'(RADIX);
                k_d   = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                for (int unsigned g = 0; g < NGRP; g++) begin
                    tsv_d[3*g +: 3] = sym_c[g];
                end
                tsv_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        din_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            k_q         <= '0;
            dig_q       <= '0;
            tsv_q       <= '0;
            tsv_valid_q <= 1'b0;
            range_err_q <= 1'b0;
            din_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            k_q         <= k_d;
            dig_q       <= dig_d;
            tsv_q       <= tsv_d;
            tsv_valid_q <= tsv_valid_d;
            range_err_q <= range_err_d;
            din_ready_q <= din_ready_d;
        end
    end

    assign bus.tsv       = tsv_q;
    assign bus.tsv_valid = tsv_valid_q;
    assign bus.range_err = range_err_q;
    assign bus.din_ready = din_ready_q;

`ifdef TNS_SELFCHK_EN
    logic [DW-1:0]   word_q, word_d;
    logic [NGRP-1:0] prev_p_q, prev_p_d;
    logic            chk_err_q, chk_err_d;
    logic [LW-1:0]   rebuilt_c;
    logic            bad_sym_c;

    // Decode the launched codeword against the MSBs it was encoded from
    always_comb begin
        word_d   = word_q;
        prev_p_d = prev_p_q;
        if (state_q == IDLE && bus.din_valid) begin
            word_d = bus.datain;
        end
        if (state_q == LAUNCH) begin
            for (int unsigned g = 0; g < NGRP; g++) begin
                prev_p_d[g] = tsv_q[3*g+2];
            end
        end

        rebuilt_c = '0;
        bad_sym_c = 1'b0;
        for (int unsigned g = 0; g < NGRP; g++) begin
            rebuilt_c = rebuilt_c
                      + LW'(tns_dec(tsv_q[3*g +: 3], prev_p_q[g])) * LW'(pow7(g));
            if (prev_p_q[g] ? (tsv_q[3*g +: 3] == 3'b011)
                            : (tsv_q[3*g +: 3] == 3'b100)) begin
                bad_sym_c = 1'b1;
            end
        end

        chk_err_d = chk_err_q;
        if (tsv_valid_q && (bad_sym_c || rebuilt_c != {3'b000, word_q})) begin
            chk_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_q    <= '0;
            prev_p_q  <= '0;
            chk_err_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            prev_p_q  <= prev_p_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign bus.chk_err = chk_err_q;
`else
    assign bus.chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_tns_cac_encoder_mc.sv
// Directed plus randomized bench for tns_cac_encoder_mc (NGRP=4, DW=12) with a base-7 reference model.
module tb_tns_cac_encoder_mc;

    localparam int unsigned NGRP = 4;
    localparam int unsigned DW   = 12;
    localparam int unsigned LAT  = NGRP + 1;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   n_forbid;
    logic [11:0] exp_tsv;

    tns_cac_encoder_mc_if #(.NGRP(NGRP), .DW(DW)) bus ();

    tns_cac_encoder_mc #(.NGRP(NGRP), .DW(DW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: base-7 digits by division, then skip the forbidden symbol per group
    function automatic logic [11:0] model_enc(input int word, input logic [11:0] prev);
        logic [11:0] r;
        int w;
        r = '0;
        w = word;
        for (int g = 0; g < 4; g++) begin
            int s;
            int t;
            s = w % 7;
            w = w / 7;
            if (prev[3*g+2]) t = (s < 3) ? s : s + 1;
            else             t = (s < 4) ? s : s + 1;
            r[3*g +: 3] = 3'(t);
        end
        return r;
    endfunction

    function automatic int golden_dec(input logic [11:0] t, input logic [11:0] prev, output int bad);
        int w;
        int mul;
        w   = 0;
        mul = 1;
        bad = 0;
        for (int g = 0; g < 4; g++) begin
            int tv;
            int thr;
            tv  = int'(t[3*g +: 3]);
            thr = prev[3*g+2] ? 2 : 3;
            if ((!prev[3*g+2] && tv == 4) || (prev[3*g+2] && tv == 3)) bad++;
            w   = w + (tv - ((tv > thr) ? 1 : 0)) * mul;
            mul = mul * 7;
        end
        return w;
    endfunction

    task automatic send(input int word, input string tag, input bit chk_lat);
        int lat;
        int dec;
        int bad;
        logic [11:0] exp;
        chk({tag, "_ready"}, 32'(bus.din_ready), 32'd1);
        bus.datain    = 12'(word);
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        bus.datain    = 12'($urandom);
        lat = 0;
        while (bus.tsv_valid !== 1'b1 && lat < 20) begin
            if (chk_lat) chk({tag, "_busy"}, 32'(bus.din_ready), 32'd0);
            step();
            lat++;
        end
        if (lat >= 20) chk({tag, "_timeout"}, 32'(lat), 32'(LAT));
        else if (chk_lat) chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        exp = model_enc(word, exp_tsv);
        chk({tag, "_tsv"}, 32'(bus.tsv), 32'(exp));
        dec = golden_dec(bus.tsv, exp_tsv, bad);
        n_forbid += bad;
        chk({tag, "_dec"}, 32'(dec), 32'(word));
        chk({tag, "_rerr"}, 32'(bus.range_err), 32'd0);
        chk({tag, "_chk"}, 32'(bus.chk_err), 32'd0);
        exp_tsv = exp;
    endtask

    task automatic send_bad(input int word, input string tag);
        bus.datain    = 12'(word);
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        chk({tag, "_rerr"}, 32'(bus.range_err), 32'd1);
        chk({tag, "_vld"}, 32'(bus.tsv_valid), 32'd0);
        chk({tag, "_tsv"}, 32'(bus.tsv), 32'(exp_tsv));
        chk({tag, "_ready"}, 32'(bus.din_ready), 32'd1);
        step();
        chk({tag, "_rerr_pulse"}, 32'(bus.range_err), 32'd0);
        chk({tag, "_vld2"}, 32'(bus.tsv_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_tsv = '0;
    endtask

    initial begin
        int pulses;
        n_chk = 0;
        n_err = 0;
        n_forbid = 0;
        rst = 1'b1;
        bus.datain = '0;
        bus.din_valid = 1'b0;
        exp_tsv = '0;
        do_reset();

        chk("rst_tsv", 32'(bus.tsv), 32'h000);
        chk("rst_vld", 32'(bus.tsv_valid), 32'd0);
        chk("rst_rerr", 32'(bus.range_err), 32'd0);
        chk("rst_ready", 32'(bus.din_ready), 32'd1);
        chk("rst_chk", 32'(bus.chk_err), 32'd0);

        send(0, "zero", 1'b1);
        chk("zero_abs", 32'(bus.tsv), 32'h000);
        step();
        chk("zero_vld_pulse", 32'(bus.tsv_valid), 32'd0);
        send(6, "six", 1'b1);
        chk("six_abs", 32'(bus.tsv), 32'h007);
        send(3, "three", 1'b1);
        chk("three_abs", 32'(bus.tsv), 32'h004);

        do_reset();
        send(2400, "max", 1'b1);
        chk("max_abs", 32'(bus.tsv), 32'hFFF);
        send(1200, "half", 1'b1);
        chk("half_abs", 32'(bus.tsv), 32'h924);

        send_bad(2401, "over_2401");
        send_bad(4095, "over_4095");

        // Reset while the third digit is being converted
        bus.datain    = 12'd2400;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_tsv = '0;
        chk("midrst_tsv", 32'(bus.tsv), 32'h000);
        chk("midrst_vld", 32'(bus.tsv_valid), 32'd0);
        chk("midrst_ready", 32'(bus.din_ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.tsv_valid === 1'b1) pulses++;
            step();
        end
        chk("midrst_nopulse", 32'(pulses), 32'd0);
        send(1200, "after_rst", 1'b1);
        chk("after_rst_abs", 32'(bus.tsv), 32'h6DB);

        for (int n = 0; n < 10000; n++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            for (int i = 0; i < gap; i++) begin
                bus.datain = 12'($urandom);
                step();
            end
            send(int'($urandom_range(0, 2400)), "rnd", 1'b0);
        end
        chk("rnd_forbidden", 32'(n_forbid), 32'd0);
        chk("final_chk_err", 32'(bus.chk_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
